p_split: RTL and testbench

//   Sequential bus distributor; the inverse of the parallel OR merge (NB_INS buses -> one bus).

---
 rtl/p_split_pkg.sv | 9 +
 rtl/p_lane_reg.sv | 24 ++
 rtl/p_split.sv | 88 ++++++++
 tb/tb_p_split.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/p_split_pkg.sv
// rtl/p_split_pkg.sv - shared sizing helpers for the p_split distributor
package p_split_pkg;

    // Lane index width: at least one bit, even for a single-lane build.
    function automatic int idx_width(input int nb_outs);
        return (nb_outs <= 1) ? 1 : $clog2(nb_outs);
    endfunction

endpackage

// File: rtl/p_lane_reg.sv
// rtl/p_lane_reg.sv - one output lane register with async reset, sync clear and write enable
module p_lane_reg #(
    parameter int BUS_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 wr_en,
    input  logic [BUS_WIDTH-1:0] d,
    output logic [BUS_WIDTH-1:0] q
);

    // Clear wins over write; the FSM never asserts both in the same cycle anyway.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= '0;
        end else if (wr_en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/p_split.sv
// rtl/p_split.sv - serial-to-parallel bus distributor filling NB_OUTS lanes into one acked frame
module p_split
    import p_split_pkg::*;
#(
    parameter  int BUS_WIDTH = 4,
    parameter  int NB_OUTS   = 3,
    localparam int IDX_W     = idx_width(NB_OUTS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [BUS_WIDTH-1:0]         in_bus,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NB_OUTS*BUS_WIDTH-1:0] out_buses,
    output logic                         out_valid,
    input  logic                         out_ack,
    output logic [IDX_W-1:0]             lane_idx
);

    localparam logic FILL = 1'b0;
    localparam logic FULL = 1'b1;

    logic               state_q;
    logic               state_d;
    logic               accept;
    logic               last_lane;
    logic               clear;
    logic [NB_OUTS-1:0] wr_en;

    // A word is taken only while filling; FULL ignores in_valid entirely.
    assign accept    = (state_q == FILL) && in_valid;
    assign last_lane = (lane_idx == IDX_W'(NB_OUTS - 1));
    assign clear     = (state_q == FULL) && out_ack;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: final-lane write completes the frame, ack releases it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL:    if (accept && last_lane) state_d = FULL;
            FULL:    if (out_ack)             state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // Handshake outputs decode from the registered state only.
    always_comb begin
        in_ready  = (state_q == FILL);
        out_valid = (state_q == FULL);
    end

    // Next-lane pointer: advances per accepted word, wraps on the final lane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_idx <= '0;
        end else if (accept) begin
            if (last_lane) begin
                lane_idx <= '0;
            end else begin
                lane_idx <= lane_idx + IDX_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NB_OUTS; k++) begin : g_lane
        assign wr_en[k] = accept && (lane_idx == IDX_W'(k));

        p_lane_reg #(
            .BUS_WIDTH(BUS_WIDTH)
        ) u_lane (
            .clk   (clk),
            .reset (reset),
            .clear (clear),
            .wr_en (wr_en[k]),
            .d     (in_bus),
            .q     (out_buses[k*BUS_WIDTH +: BUS_WIDTH])
        );
    end

endmodule

// File: tb/tb_p_split.sv
// tb/tb_p_split.sv - randomized scoreboard bench for p_split (3-lane and 1-lane builds)
module tb_p_split;

    localparam int W = 4;
    localparam int N = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [W-1:0]   in_bus;
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] out_buses;
    logic           out_valid;
    logic           out_ack;
    logic [1:0]     lane_idx;

    logic [W-1:0]   in_bus1;
    logic           in_valid1;
    logic           in_ready1;
    logic [W-1:0]   out_buses1;
    logic           out_valid1;
    logic           out_ack1;
    logic [0:0]     lane_idx1;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    p_split #(.BUS_WIDTH(W), .NB_OUTS(N)) u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_buses (out_buses),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .lane_idx  (lane_idx)
    );

    p_split #(.BUS_WIDTH(W), .NB_OUTS(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .in_bus    (in_bus1),
        .in_valid  (in_valid1),
        .in_ready  (in_ready1),
        .out_buses (out_buses1),
        .out_valid (out_valid1),
        .out_ack   (out_ack1),
        .lane_idx  (lane_idx1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: words accepted so far in the current frame, and whether a frame is pending.
    logic [W-1:0]   m_words[$];
    bit             m_full = 1'b0;
    logic [N*W-1:0] exp_q[$];

    initial begin
        logic [N*W-1:0] frame;
        forever begin
            @(posedge clk or posedge reset);
            if (reset) begin
                m_words.delete();
                m_full = 1'b0;
                exp_q.delete();
            end else if (m_full) begin
                if (out_ack) m_full = 1'b0;
            end else if (in_valid) begin
                m_words.push_back(in_bus);
                if (m_words.size() == N) begin
                    frame = '0;
                    for (int k = 0; k < N; k++) frame[k*W +: W] = m_words[k];
                    exp_q.push_back(frame);
                    m_words.delete();
                    m_full = 1'b1;
                end
            end
        end
    end

    // Monitor: handshake/status each cycle, frames popped from the scoreboard when out_valid rises.
    initial begin
        bit             prev_valid = 1'b0;
        logic [N*W-1:0] held = '0;
        logic [N*W-1:0] partial;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_valid = 1'b0;
            end else begin
                check("in_ready", 64'(in_ready), 64'(!m_full));
                check("out_valid", 64'(out_valid), 64'(m_full));
                check("lane_idx", 64'(lane_idx), 64'(m_words.size()));
                if (out_valid && !prev_valid) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL frame_unexpected: got %0h expected none", out_buses);
                    end else begin
                        held = exp_q.pop_front();
                        check("frame", 64'(out_buses), 64'(held));
                    end
                end else if (out_valid) begin
                    check("frame_hold", 64'(out_buses), 64'(held));
                end else begin
                    partial = '0;
                    foreach (m_words[k]) partial[k*W +: W] = m_words[k];
                    check("lanes_partial", 64'(out_buses), 64'(partial));
                end
                prev_valid = out_valid;
            end
        end
    end

    task automatic send(input logic [W-1:0] w);
        in_valid = 1'b1;
        in_bus   = w;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic ack;
        out_ack = 1'b1;
        @(posedge clk);
        #1 out_ack = 1'b0;
    endtask

    task automatic send1(input logic [W-1:0] w);
        in_valid1 = 1'b1;
        in_bus1   = w;
        @(posedge clk);
        #1 in_valid1 = 1'b0;
    endtask

    task automatic ack1;
        out_ack1 = 1'b1;
        @(posedge clk);
        #1 out_ack1 = 1'b0;
    endtask

    initial begin
        #200000;
        miscompares++;
        $display("FAIL timeout: simulation did not complete");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        reset     = 1'b1;
        in_bus    = '0;
        in_valid  = 1'b0;
        out_ack   = 1'b0;
        in_bus1   = '0;
        in_valid1 = 1'b0;
        out_ack1  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        @(negedge clk);
        check("rst_out_buses", 64'(out_buses), 64'h000);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_lane_idx", 64'(lane_idx), 64'd0);

        send(4'b1001);
        send(4'b1011);
        send(4'b0110);
        @(negedge clk);
        check("fill_frame", 64'(out_buses), 64'b0110_1011_1001);
        check("fill_out_valid", 64'(out_valid), 64'd1);
        check("fill_in_ready", 64'(in_ready), 64'd0);

        in_valid = 1'b1;
        in_bus   = 4'b1111;
        repeat (5) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_frame", 64'(out_buses), 64'b0110_1011_1001);
        check("bp_lane_idx", 64'(lane_idx), 64'd0);

        ack();
        @(negedge clk);
        check("ack_out_valid", 64'(out_valid), 64'd0);
        check("ack_in_ready", 64'(in_ready), 64'd1);
        check("ack_cleared", 64'(out_buses), 64'h000);

        send(4'b0001);
        send(4'b0010);
        send(4'b0100);
        @(negedge clk);
        check("frame2", 64'(out_buses), 64'b0100_0010_0001);
        ack();

        send(4'b1010);
        repeat (3) @(posedge clk);
        #1;
        send(4'b0101);
        @(negedge clk);
        check("gap_lane_idx", 64'(lane_idx), 64'd2);
        #2 reset = 1'b1;
        #1;
        check("async_lane_idx", 64'(lane_idx), 64'd0);
        check("async_lanes", 64'(out_buses), 64'h000);
        check("async_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;

        for (int c = 0; c < 400; c++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            in_bus   = W'($urandom);
            out_ack  = ($urandom_range(0, 2) == 0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        out_ack  = 1'b0;

        send1(4'b1100);
        @(negedge clk);
        check("n1_frame", 64'(out_buses1), 64'b1100);
        check("n1_out_valid", 64'(out_valid1), 64'd1);
        check("n1_in_ready", 64'(in_ready1), 64'd0);
        check("n1_lane_idx", 64'(lane_idx1), 64'd0);
        send1(4'b0011);
        @(negedge clk);
        check("n1_hold", 64'(out_buses1), 64'b1100);
        ack1();
        @(negedge clk);
        check("n1_ack_valid", 64'(out_valid1), 64'd0);
        check("n1_ack_ready", 64'(in_ready1), 64'd1);
        check("n1_ack_clear", 64'(out_buses1), 64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] w;
            w = W'($urandom);
            send1(w);
            @(negedge clk);
            check("n1_rand_frame", 64'(out_buses1), 64'(w));
            check("n1_rand_idx", 64'(lane_idx1), 64'd0);
            ack1();
            @(negedge clk);
            check("n1_rand_clear", 64'(out_buses1), 64'd0);
        end

        repeat (2) @(posedge clk);
        if (exp_q.size() > 1) begin
            vectors++;
            miscompares++;
            $display("FAIL scoreboard_leftover: got %0d frames expected at most 1", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
